router_fsm: RTL



---
 rtl/router_pkg.sv | 32 +++
 rtl/router_fsm.sv | 110 +++++++++++
 2 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 packet router control path.
package router_pkg;

  typedef enum logic [7:0] {
    DECODE_ADDRESS     = 8'b0000_0001,
    LOAD_FIRST_DATA    = 8'b0000_0010,
    LOAD_DATA          = 8'b0000_0100,
    LOAD_PARITY        = 8'b0000_1000,
    FIFO_FULL_STATE    = 8'b0001_0000,
    LOAD_AFTER_FULL    = 8'b0010_0000,
    WAIT_TILL_EMPTY    = 8'b0100_0000,
    CHECK_PARITY_ERROR = 8'b1000_0000
  } state_t;

  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_0       = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_1       = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_2       = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  // Pick one per-port flag by destination address; address 3 maps to no port.
  function automatic logic port_flag(input logic [2:0] flags, input logic [ADDR_W-1:0] a);
    case (a)
      ADDR_0:  port_flag = flags[0];
      ADDR_1:  port_flag = flags[1];
      ADDR_2:  port_flag = flags[2];
      default: port_flag = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, waits for the target FIFO,
// sequences header/payload/parity loading and suspends while the FIFO is full.
module router_fsm
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr, next_addr;
  logic [2:0]        empties, softs;
  logic              sel_empty, sel_soft;
  logic              write_enb_d, detect_add_d, lfd_d, ld_d, laf_d, full_d, rst_int_d, busy_d;

  assign empties   = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign softs     = {soft_reset_2, soft_reset_1, soft_reset_0};
  assign sel_empty = port_flag(empties, addr);
  assign sel_soft  = port_flag(softs, addr);

  // Next state, next address and the Moore outputs of the state being entered.
  always_comb begin
    next_state = state;
    next_addr  = addr;

    case (state)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          next_addr = data_in;
          if (data_in != ADDR_INVALID)
            next_state = port_flag(empties, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY:    if (sel_empty) next_state = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:    next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       next_state = FIFO_FULL_STATE;
        else if (!pkt_valid) next_state = LOAD_PARITY;
      end
      LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      FIFO_FULL_STATE:    if (!fifo_full) next_state = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)        next_state = DECODE_ADDRESS;
        else if (low_pkt_valid) next_state = LOAD_PARITY;
        else                    next_state = LOAD_DATA;
      end
      default:            next_state = DECODE_ADDRESS;
    endcase

    // A soft reset on the selected port aborts the packet from any active state.
    if (sel_soft && state != DECODE_ADDRESS) next_state = DECODE_ADDRESS;

    detect_add_d = (next_state == DECODE_ADDRESS);
    lfd_d        = (next_state == LOAD_FIRST_DATA);
    ld_d         = (next_state == LOAD_DATA);
    laf_d        = (next_state == LOAD_AFTER_FULL);
    full_d       = (next_state == FIFO_FULL_STATE);
    rst_int_d    = (next_state == CHECK_PARITY_ERROR);
    write_enb_d  = (next_state == LOAD_DATA) || (next_state == LOAD_PARITY) ||
                   (next_state == LOAD_AFTER_FULL);
    busy_d       = (next_state != DECODE_ADDRESS) && (next_state != LOAD_DATA);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= DECODE_ADDRESS;
      addr          <= ADDR_0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= next_state;
      addr          <= next_addr;
      detect_add    <= detect_add_d;
      lfd_state     <= lfd_d;
      ld_state      <= ld_d;
      laf_state     <= laf_d;
      full_state    <= full_d;
      rst_int_reg   <= rst_int_d;
      write_enb_reg <= write_enb_d;
      busy          <= busy_d;
    end
  end

endmodule
